// File: rtl/divider_16bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_16bit_seq
// Brief    : Multi-cycle signed/unsigned restoring divider, one quotient bit
//            per cycle, start/done handshake, quotient/remainder/flags.
// Revision : 1.0 - initial release
// ============================================================================
module divider_16bit_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Div_ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ,
    output logic             O
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_b_raw;
    logic               r_signed;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH:0]     r_rem;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_dz;
    logic               r_o;

    logic               w_accept;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_fit;
    logic               w_neg_q;
    logic               w_neg_r;
    logic               w_dz;
    logic               w_ovf;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_a_mag  = (Div_ctrl && A[WIDTH-1]) ? -A : A;
    assign w_b_mag  = (Div_ctrl && B[WIDTH-1]) ? -B : B;

    // One restoring step; the extra top bit of w_diff is the borrow.
    assign w_shift  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_divisor};
    assign w_fit    = ~w_diff[WIDTH+1];

    assign w_neg_q  = r_signed && (r_a_raw[WIDTH-1] ^ r_b_raw[WIDTH-1]);
    assign w_neg_r  = r_signed && r_a_raw[WIDTH-1];
    assign w_dz     = (r_b_raw == '0);
    assign w_ovf    = r_signed && (r_a_raw == c_MOST_NEG) && (r_b_raw == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the state, so they trail it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_a_raw   <= '0;
            r_b_raw   <= '0;
            r_signed  <= 1'b0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
            r_dz      <= 1'b0;
            r_o       <= 1'b0;
        end else begin
            r_busy <= (r_state == S_RUN);
            r_done <= (r_state == S_DONE);

            if (w_accept) begin
                r_a_raw   <= A;
                r_b_raw   <= B;
                r_signed  <= Div_ctrl;
                r_divisor <= w_b_mag;
                r_quo     <= w_a_mag;
                r_rem     <= '0;
                r_cnt     <= c_CNT_INIT;
            end else if (r_state == S_RUN) begin
                r_rem <= w_fit ? w_diff[WIDTH:0] : w_shift;
                r_quo <= {r_quo[WIDTH-2:0], w_fit};
                r_cnt <= r_cnt - c_CNT_ONE;
            end

            if (r_state == S_DONE) begin
                r_dz <= w_dz;
                r_o  <= w_ovf && !w_dz;
                if (w_dz) begin
                    r_q <= '1;
                    r_r <= r_a_raw;
                end else begin
                    r_q <= w_neg_q ? -r_quo : r_quo;
                    r_r <= w_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Q    = r_q;
    assign R    = r_r;
    assign DZ   = r_dz;
    assign O    = r_o;

endmodule
`default_nettype wire
